// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: 2-bit counter states,
// default table size, datapath width and RISC-V control-flow opcodes.
package bp_pkg;

  localparam int XLEN            = 32;
  localparam int DEFAULT_ENTRIES = 16;

  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } ctr_e;

  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter next-state logic.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_e state_i,
  input  logic taken_i,
  output ctr_e state_o
);

  always_comb begin
    state_o = state_i;
    if (taken_i) begin
      if (state_i != ST) state_o = ctr_e'(state_i + 2'd1);
    end else begin
      if (state_i != SN) state_o = ctr_e'(state_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters, EX-stage mispredict detection
// and optional performance counters (enabled by defining BP_PERF_CNT_EN).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] perf_ctrl_cnt,
  output logic [XLEN-1:0] perf_miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  logic [ENTRIES-1:0]             valid_vec;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_vec;
  logic [ENTRIES-1:0][XLEN-1:0]   target_vec;
  logic [ENTRIES-1:0]             jump_vec;
  logic [ENTRIES-1:0][1:0]        ctr_vec;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd;
  ctr_e             ctr_upd;

  // PC bits [1:0] never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

  assign upd    = ex_valid & (ex_is_branch | ex_is_jump);
  assign ex_hit = valid_vec[ex_idx] & (tag_vec[ex_idx] == ex_tag);

  bp_sat_counter u_sat (
    .state_i (ctr_e'(ctr_vec[ex_idx])),
    .taken_i (ex_taken),
    .state_o (ctr_upd)
  );

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign if_hit      = valid_vec[if_idx] & (tag_vec[if_idx] == if_tag);
  assign pred_taken  = if_hit & (jump_vec[if_idx] | ctr_vec[if_idx][1]);
  assign pred_target = pred_taken ? target_vec[if_idx] : pc_plus4(if_pc);

  assign mispredict  = upd & ((ex_pred_taken != ex_taken) |
                              (ex_taken & (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : pc_plus4(ex_pc);

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic             sel;
    logic             valid_q,  valid_d;
    logic [TAG_W-1:0] tag_q,    tag_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             jump_q,   jump_d;
    logic [1:0]       ctr_q,    ctr_d;

    assign sel = upd & (ex_idx == IDX_W'(gi));

    always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      jump_d   = jump_q;
      ctr_d    = ctr_q;
      if (sel) begin
        if (ex_taken) begin
          // Taken always (re)claims the entry; a fresh allocation starts weakly taken.
          valid_d  = 1'b1;
          tag_d    = ex_tag;
          target_d = ex_target;
          jump_d   = ex_is_jump;
          ctr_d    = ex_hit ? ctr_upd : WT;
        end else if (ex_hit) begin
          ctr_d    = ctr_upd;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
        jump_q   <= 1'b0;
        ctr_q    <= WN;
      end else begin
        valid_q  <= valid_d;
        tag_q    <= tag_d;
        target_q <= target_d;
        jump_q   <= jump_d;
        ctr_q    <= ctr_d;
      end
    end

    assign valid_vec[gi]  = valid_q;
    assign tag_vec[gi]    = tag_q;
    assign target_vec[gi] = target_q;
    assign jump_vec[gi]   = jump_q;
    assign ctr_vec[gi]    = ctr_q;
  end

`ifdef BP_PERF_CNT_EN
  logic [XLEN-1:0] perf_ctrl_q, perf_ctrl_d;
  logic [XLEN-1:0] perf_miss_q, perf_miss_d;

  always_comb begin
    perf_ctrl_d = perf_ctrl_q;
    perf_miss_d = perf_miss_q;
    if (upd && (perf_ctrl_q != '1))        perf_ctrl_d = perf_ctrl_q + 32'd1;
    if (mispredict && (perf_miss_q != '1)) perf_miss_d = perf_miss_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ctrl_q <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_ctrl_q <= perf_ctrl_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign perf_ctrl_cnt = perf_ctrl_q;
  assign perf_miss_cnt = perf_miss_q;
`else
  assign perf_ctrl_cnt = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule
